spi_xfer_ctrl: RTL and testbench
================================

# spi_xfer_ctrl

Transaction sequencer that sits in front of the SPI `IOModule` and turns one requester command into a complete SPI exchange: load the Tx buffer, fire `send`, wait for `io_complete`, read the Rx buffer back and return the received bytes. It replaces the hand-written stimulus state machine around `IOModule` with a reusable valid/ready block that a CPU-side bus bridge can drive.

## Interface
- `MAX_BYTES`, 4: largest transfer length; also the Tx/Rx buffer depth used.
- `ADDR_W`, 4: width of `tx_addr`/`rx_addr`.
- `TIMEOUT_CYC`, 4096: watchdog limit in `sysClk` cycles; used only with `SPI_XFER_TIMEOUT_EN`.
- `sysClk  in  1`  system clock. Single clock domain.
- `reset  in  1`  synchronous, active-high reset.
- `req_valid  in  1`  command valid.
- `req_ready  out  1`  command accepted when valid & ready.
- `req_len  in  3`  byte count; legal range 1..`MAX_BYTES`.
- `req_data  in  8*MAX_BYTES`  Tx bytes; byte i = `req_data[8i+7:8i]`.
- `rsp_valid  out  1`  response valid.
- `rsp_ready  in  1`  response consumed when valid & ready.
- `rsp_data  out  8*MAX_BYTES`  Rx bytes; same packing; bytes ≥ len are zero.
- `rsp_err  out  1`  bad length or timeout.
- `tx_addr  out  ADDR_W`  Tx buffer address.
- `tx_byte  out  DATA_WIDTH`  Tx write data.
- `tx_wr  out  1`  Tx write strobe, active low.
- `send  out  1`  start transfer, active low.
- `io_complete  in  1`  high when `IOModule` is idle/finished.
- `rx_addr  out  ADDR_W`  Rx buffer address.
- `rx_byte  in  DATA_WIDTH`  Rx read data, valid the cycle after `rx_rd` is low.
- `rx_rd  out  1`  Rx read strobe, active low.

## Operation
- States: `XIdle`, `XWrite`, `XWriteNext`, `XSend`, `XArm`, `XWait`, `XRead`, `XCapture`, `XResp`.
- `XIdle`: `req_ready`=1. On accept, latch `req_len`/`req_data`, clear byte index `idx` and the response register. If len is 0 or >`MAX_BYTES`, set `rsp_err`=1 and go to `XResp`. Otherwise go to `XWrite`.
- `XWrite`: drive `tx_wr`=0, `tx_addr`=`idx`, `tx_byte`=byte `idx`. Go to `XWriteNext`.
- `XWriteNext`: `tx_wr`=1. Increment `idx`. If `idx`=len-1, clear `idx` and go to `XSend`; else go to `XWrite`.
- `XSend`: `send`=0 for exactly one cycle. Go to `XArm`.
- `XArm`: wait for `io_complete`=0 (transfer has started), then go to `XWait`.
- `XWait`: wait for `io_complete`=1, then go to `XRead`.
- `XRead`: `rx_rd`=0, `rx_addr`=`idx`. Go to `XCapture`.
- `XCapture`: store `rx_byte` into `rsp_data` byte `idx`. If last byte, go to `XResp`; else increment `idx` and go to `XRead`.
- `XResp`: `rsp_valid`=1; `rsp_data`/`rsp_err` are held stable. On `rsp_ready`, go to `XIdle`. Only one command is in flight at a time.
- `idx` width is clog2(`MAX_BYTES`); it never wraps past len-1.

## Timing
- Reset values: `req_ready`=0 during reset, then 1 in `XIdle`. `rsp_valid`=0, `rsp_err`=0, `rsp_data`=0. `tx_wr`=`send`=`rx_rd`=1. Addresses and `tx_byte` are 0.
- Reset mid-transfer returns to `XIdle` on the next edge. The in-flight command is dropped with no response. Strobes go high immediately at that edge.
- All outputs are registered or state-decoded; no combinational path from `io_complete` or `rx_byte` to any output.
- Cycle count from accept to `rsp_valid`, excluding the SPI wait: 2·len (load) + 1 (send) + 2·len (read) + 1.
- Bad-length command: `rsp_valid` is asserted 1 cycle after accept.
- `io_complete` already high while in `XArm` is ignored. The block waits for the low→high sequence so a stale completion is never consumed.
- `rsp_ready` held high in advance: the response completes in the single `XResp` cycle.

## Configuration
- `SPI_XFER_TIMEOUT_EN`, defined:
  - A counter runs in `XArm`/`XWait`.
  - Reaching `TIMEOUT_CYC` forces `XResp` with `rsp_err`=1 and `rsp_data`=0.
  - The counter clears on every entry to `XSend`.
- Undefined: no counter; the block waits for `io_complete` indefinitely. `rsp_err` reports only bad lengths.

## Structure
- Shared package holds:
  - `XferState` enum.
  - `DATA_WIDTH` reuse.
  - Localparam for the max byte count.
- One sub-module, `xfer_watchdog` (counter + compare + clear), is instantiated only under `SPI_XFER_TIMEOUT_EN`.

## Test plan
- Loopback slave, len=3, data 0x00_32_2A_A1:
  - Tx writes addr 0,1,2 = A1,2A,32.
  - One `send` low pulse.
  - `rsp_data` = slave reply bytes, byte 3 = 0, `rsp_err`=0.
- len=4, data 0xDEADBEEF: four `tx_wr` pulses, four `rx_rd` pulses at addr 0..3, response returns all four bytes.
- len=0, then len=5: each gives `rsp_valid` 1 cycle after accept, `rsp_err`=1, zero `tx_wr`/`send` activity.
- `rsp_ready` held low 10 cycles: `rsp_valid`, `rsp_data` and `rsp_err` stay stable; `req_ready`=0 throughout.
- `reset` asserted during `XWait`: next edge `send`=`tx_wr`=`rx_rd`=1, `rsp_valid`=0, `req_ready`=1 once reset is released; a new len=1 command completes normally.
- With `SPI_XFER_TIMEOUT_EN` and `TIMEOUT_CYC`=16, `io_complete` stuck low: `rsp_err`=1 exactly 16 cycles after entering `XArm`.

Source files
------------

// File: rtl/spi_xfer_ctrl_pkg.sv
// Shared types and constants for the SPI transaction sequencer in front of IOModule.
package spi_xfer_ctrl_pkg;

    localparam int DATA_WIDTH     = 8;
    localparam int XFER_MAX_BYTES = 4;
    localparam int LEN_W          = 3;

    typedef enum logic [3:0] {
        XIdle,
        XWrite,
        XWriteNext,
        XSend,
        XArm,
        XWait,
        XRead,
        XCapture,
        XResp
    } XferState;

endpackage

// File: rtl/spi_xfer_ctrl_watchdog.sv
// Cycle watchdog for the SPI wait phase: cleared at send, counts while active,
// flags expiry on the cycle the count reaches TIMEOUT_CYC.
module xfer_watchdog #(
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic active,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (active && (count_q != LIMIT)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Expiry is decoded one count early so the owner leaves on the TIMEOUT_CYC-th edge.
    assign expired = active && (count_q == LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// Valid/ready sequencer turning one command into a full IOModule exchange.
// Optional SPI wait watchdog enabled by defining SPI_XFER_TIMEOUT_EN.
module spi_xfer_ctrl
    import spi_xfer_ctrl_pkg::*;
#(
    parameter int MAX_BYTES   = XFER_MAX_BYTES,
    parameter int ADDR_W      = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                            sysClk,
    input  logic                            reset,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic [LEN_W-1:0]                req_len,
    input  logic [DATA_WIDTH*MAX_BYTES-1:0] req_data,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [DATA_WIDTH*MAX_BYTES-1:0] rsp_data,
    output logic                            rsp_err,
    output logic [ADDR_W-1:0]               tx_addr,
    output logic [DATA_WIDTH-1:0]           tx_byte,
    output logic                            tx_wr,
    output logic                            send,
    input  logic                            io_complete,
    output logic [ADDR_W-1:0]               rx_addr,
    input  logic [DATA_WIDTH-1:0]           rx_byte,
    output logic                            rx_rd
);

    localparam int IDX_W = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
    localparam int BUS_W = DATA_WIDTH * MAX_BYTES;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BYTES);

    XferState         state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [BUS_W-1:0] tx_data_q, tx_data_d;
    logic [BUS_W-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d;
    logic             last_byte;
    logic             timeout_hit;

    assign last_byte = (LEN_W'(idx_q) == (len_q - LEN_W'(1)));

`ifdef SPI_XFER_TIMEOUT_EN
    xfer_watchdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_watchdog (
        .clk    (sysClk),
        .rst    (reset),
        .clear  (state_q == XSend),
        .active ((state_q == XArm) || (state_q == XWait)),
        .expired(timeout_hit)
    );
`else
    // Without the watchdog the block waits on io_complete forever.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYC;
    assign timeout_hit        = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        len_d      = len_q;
        tx_data_d  = tx_data_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            XIdle: begin
                if (req_valid && req_ready) begin
                    len_d      = req_len;
                    tx_data_d  = req_data;
                    idx_d      = '0;
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b0;
                    if ((req_len == '0) || (req_len > MAX_LEN)) begin
                        rsp_err_d = 1'b1;
                        state_d   = XResp;
                    end else begin
                        state_d = XWrite;
                    end
                end
            end
            XWrite:     state_d = XWriteNext;
            XWriteNext: begin
                if (last_byte) begin
                    idx_d   = '0;
                    state_d = XSend;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = XWrite;
                end
            end
            XSend: state_d = XArm;
            // A completion already high here is stale; only a fresh low->high counts.
            XArm:  if (!io_complete) state_d = XWait;
            XWait: if (io_complete) state_d = XRead;
            XRead: state_d = XCapture;
            XCapture: begin
                rsp_data_d[DATA_WIDTH*idx_q +: DATA_WIDTH] = rx_byte;
                if (last_byte) begin
                    state_d = XResp;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = XRead;
                end
            end
            XResp:   if (rsp_ready) state_d = XIdle;
            default: state_d = XIdle;
        endcase
        if (timeout_hit) begin
            rsp_err_d  = 1'b1;
            rsp_data_d = '0;
            state_d    = XResp;
        end
    end

    always_ff @(posedge sysClk) begin
        if (reset) begin
            state_q    <= XIdle;
            idx_q      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    always_ff @(posedge sysClk) begin
        len_q     <= len_d;
        tx_data_q <= tx_data_d;
    end

    // Strobes are pure state decodes so reset raises them on the same edge.
    assign req_ready = (state_q == XIdle) && !reset;
    assign rsp_valid = (state_q == XResp);
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign tx_wr     = (state_q != XWrite);
    assign send      = (state_q != XSend);
    assign rx_rd     = (state_q != XRead);
    assign tx_addr   = ADDR_W'(idx_q);
    assign rx_addr   = ADDR_W'(idx_q);
    assign tx_byte   = (state_q == XWrite) ? tx_data_q[DATA_WIDTH*idx_q +: DATA_WIDTH] : '0;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Self-checking bench for spi_xfer_ctrl with a behavioural IOModule slave that
// replies with the bit-inverse of each Tx buffer byte.
module tb_spi_xfer_ctrl;
    import spi_xfer_ctrl_pkg::*;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } rsp_t;

    logic        sysClk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [2:0]  req_len = '0;
    logic [31:0] req_data = '0;
    logic        rsp_ready = 1'b1;
    logic        io_complete = 1'b1;
    logic [7:0]  rx_byte = '0;
    logic        req_ready, rsp_valid, rsp_err, tx_wr, send, rx_rd;
    logic [31:0] rsp_data;
    logic [3:0]  tx_addr, rx_addr;
    logic [7:0]  tx_byte;

    int   checks = 0;
    int   errors = 0;
    rsp_t exp_q[$];

    // Slave model state
    logic [7:0]  tx_mem[16];
    logic [7:0]  rx_mem[16];
    int          busy = 0;
    int          busy_len = 3;
    bit          stuck = 1'b0;
    int          cyc = 0;
    int          send_cnt = 0;
    int          arm_mark = 0;
    logic [11:0] wr_log[$];
    logic [3:0]  rd_log[$];

    always #5 sysClk = ~sysClk;

    spi_xfer_ctrl #(
        .MAX_BYTES  (4),
        .ADDR_W     (4),
        .TIMEOUT_CYC(16)
    ) dut (
        .sysClk     (sysClk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_len    (req_len),
        .req_data   (req_data),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .tx_addr    (tx_addr),
        .tx_byte    (tx_byte),
        .tx_wr      (tx_wr),
        .send       (send),
        .io_complete(io_complete),
        .rx_addr    (rx_addr),
        .rx_byte    (rx_byte),
        .rx_rd      (rx_rd)
    );

    initial begin
        for (int i = 0; i < 16; i++) begin
            tx_mem[i] = 8'h11;
            rx_mem[i] = 8'hEE;
        end
    end

    always @(posedge sysClk) begin
        cyc <= cyc + 1;
        if (tx_wr === 1'b0) begin
            tx_mem[tx_addr] <= tx_byte;
            wr_log.push_back({tx_addr, tx_byte});
        end
        if (rx_rd === 1'b0) begin
            rx_byte <= rx_mem[rx_addr];
            rd_log.push_back(rx_addr);
        end
        if (send === 1'b0) begin
            send_cnt    <= send_cnt + 1;
            io_complete <= 1'b0;
            busy        <= busy_len;
            arm_mark    <= cyc + 1;
            for (int i = 0; i < 16; i++) rx_mem[i] <= ~tx_mem[i];
        end else if (!stuck) begin
            if (busy > 1) begin
                busy <= busy - 1;
            end else begin
                busy        <= 0;
                io_complete <= 1'b1;
            end
        end
    end

    function automatic logic [31:0] model_reply(input logic [2:0] len, input logic [31:0] d);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            if (i < int'(len)) r[8*i +: 8] = ~d[8*i +: 8];
        end
        return r;
    endfunction

    function automatic void push_expect(input logic [2:0] len, input logic [31:0] d);
        rsp_t e;
        if ((len == 3'd0) || (len > 3'd4)) begin
            e.data = '0;
            e.err  = 1'b1;
        end else begin
            e.data = model_reply(len, d);
            e.err  = 1'b0;
        end
        exp_q.push_back(e);
    endfunction

    task automatic send_cmd(input logic [2:0] len, input logic [31:0] data);
        bit ok;
        ok = 1'b0;
        @(posedge sysClk);
        #1;
        req_valid = 1'b1;
        req_len   = len;
        req_data  = data;
        for (int i = 0; i < 200; i++) begin
            @(negedge sysClk);
            if (req_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_bound: req_ready=%b never reached required 1", req_ready);
        end
        @(posedge sysClk);
        #1;
        req_valid = 1'b0;
        req_len   = '0;
        req_data  = '0;
    endtask

    task automatic get_rsp(output bit ok, output rsp_t e);
        ok = 1'b0;
        e  = '0;
        for (int i = 0; i < 300; i++) begin
            @(negedge sysClk);
            if (rsp_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL rsp_bound: rsp_valid=%b never reached required 1", rsp_valid);
        end else if (exp_q.size() == 0) begin
            ok = 1'b0;
            checks++;
            errors++;
            $display("FAIL rsp_unexpected: got response %h with empty scoreboard, required none", rsp_data);
        end else begin
            e = exp_q.pop_front();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge sysClk);
        @(negedge sysClk);
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready: got %b required 0", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b required 0", rsp_valid); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL rst_rsp_err: got %b required 0", rsp_err); end
        checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL rst_rsp_data: got %h required 0", rsp_data); end
        checks++; if ({tx_wr, send, rx_rd} !== 3'b111) begin errors++; $display("FAIL rst_strobes: got %b required 111", {tx_wr, send, rx_rd}); end
        checks++; if ({tx_addr, rx_addr, tx_byte} !== 16'h0) begin errors++; $display("FAIL rst_addr_byte: got %h required 0", {tx_addr, rx_addr, tx_byte}); end
        @(posedge sysClk);
        #1 reset = 1'b0;
        @(negedge sysClk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b required 1", req_ready); end
    endtask

    task automatic test_len3();
        logic [31:0] d;
        bit          ok;
        rsp_t        e;
        int          s0;
        d  = 32'h0032_2AA1;
        s0 = send_cnt;
        wr_log.delete();
        rd_log.delete();
        push_expect(3'd3, d);
        send_cmd(3'd3, d);
        get_rsp(ok, e);
        if (ok) begin
            checks++; if (rsp_data !== e.data) begin errors++; $display("FAIL len3_data: got %h required %h", rsp_data, e.data); end
            checks++; if (rsp_err !== e.err) begin errors++; $display("FAIL len3_err: got %b required %b", rsp_err, e.err); end
        end
        checks++; if (wr_log.size() != 3) begin errors++; $display("FAIL len3_wr_count: got %0d required 3", wr_log.size()); end
        for (int i = 0; i < 3 && i < wr_log.size(); i++) begin
            checks++;
            if (wr_log[i] !== {4'(i), d[8*i +: 8]}) begin
                errors++; $display("FAIL len3_wr_%0d: got %h required %h", i, wr_log[i], {4'(i), d[8*i +: 8]});
            end
        end
        checks++; if (send_cnt - s0 != 1) begin errors++; $display("FAIL len3_send_pulses: got %0d required 1", send_cnt - s0); end
    endtask

    task automatic test_len4();
        logic [31:0] d;
        bit          ok;
        rsp_t        e;
        d = 32'hDEAD_BEEF;
        wr_log.delete();
        rd_log.delete();
        push_expect(3'd4, d);
        send_cmd(3'd4, d);
        get_rsp(ok, e);
        if (ok) begin
            checks++; if (rsp_data !== e.data) begin errors++; $display("FAIL len4_data: got %h required %h", rsp_data, e.data); end
            checks++; if (rsp_err !== e.err) begin errors++; $display("FAIL len4_err: got %b required %b", rsp_err, e.err); end
        end
        checks++; if (wr_log.size() != 4) begin errors++; $display("FAIL len4_wr_count: got %0d required 4", wr_log.size()); end
        checks++; if (rd_log.size() != 4) begin errors++; $display("FAIL len4_rd_count: got %0d required 4", rd_log.size()); end
        for (int i = 0; i < 4 && i < rd_log.size(); i++) begin
            checks++;
            if (rd_log[i] !== 4'(i)) begin errors++; $display("FAIL len4_rd_addr_%0d: got %0d required %0d", i, rd_log[i], i); end
        end
    endtask

    task automatic test_bad_len();
        logic [2:0] lens[2];
        rsp_t       e;
        int         s0;
        int         w0;
        lens[0] = 3'd0;
        lens[1] = 3'd5;
        for (int k = 0; k < 2; k++) begin
            s0 = send_cnt;
            w0 = wr_log.size();
            push_expect(lens[k], 32'hA5A5_A5A5);
            send_cmd(lens[k], 32'hA5A5_A5A5);
            @(negedge sysClk);
            e = exp_q.pop_front();
            checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL badlen%0d_latency: rsp_valid got %b required 1", lens[k], rsp_valid); end
            checks++; if (rsp_err !== e.err) begin errors++; $display("FAIL badlen%0d_err: got %b required %b", lens[k], rsp_err, e.err); end
            checks++; if (rsp_data !== e.data) begin errors++; $display("FAIL badlen%0d_data: got %h required %h", lens[k], rsp_data, e.data); end
            @(negedge sysClk);
            checks++; if ((send_cnt != s0) || (wr_log.size() != w0)) begin
                errors++; $display("FAIL badlen%0d_activity: send %0d wr %0d required 0 0", lens[k], send_cnt - s0, wr_log.size() - w0);
            end
        end
    endtask

    task automatic test_backpressure();
        bit   ok;
        rsp_t e;
        rsp_ready = 1'b0;
        push_expect(3'd2, 32'h0000_C35A);
        send_cmd(3'd2, 32'h0000_C35A);
        get_rsp(ok, e);
        if (ok) begin
            for (int i = 0; i < 10; i++) begin
                @(negedge sysClk);
                checks++;
                if ((rsp_valid !== 1'b1) || (rsp_data !== e.data) || (rsp_err !== e.err) || (req_ready !== 1'b0)) begin
                    errors++;
                    $display("FAIL hold_cycle_%0d: got v=%b d=%h e=%b rdy=%b required 1 %h %b 0", i, rsp_valid, rsp_data, rsp_err, req_ready, e.data, e.err);
                end
            end
        end
        @(posedge sysClk);
        #1 rsp_ready = 1'b1;
        @(posedge sysClk);
        @(negedge sysClk);
        checks++; if ((rsp_valid !== 1'b0) || (req_ready !== 1'b1)) begin
            errors++; $display("FAIL hold_release: got v=%b rdy=%b required 0 1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_back_to_back();
        bit   ok;
        rsp_t e;
        rsp_ready = 1'b1;
        push_expect(3'd1, 32'h0000_0033);
        send_cmd(3'd1, 32'h0000_0033);
        get_rsp(ok, e);
        if (ok) begin
            checks++; if (rsp_data !== e.data) begin errors++; $display("FAIL b2b_first_data: got %h required %h", rsp_data, e.data); end
            @(negedge sysClk);
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_single_cycle: rsp_valid got %b required 0", rsp_valid); end
        end
        push_expect(3'd2, 32'h0000_F00F);
        send_cmd(3'd2, 32'h0000_F00F);
        get_rsp(ok, e);
        if (ok) begin
            checks++; if ((rsp_data !== e.data) || (rsp_err !== e.err)) begin
                errors++; $display("FAIL b2b_second: got %h/%b required %h/%b", rsp_data, rsp_err, e.data, e.err);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit   ok;
        bit   seen;
        rsp_t e;
        int   s0;
        busy_len = 12;
        s0 = send_cnt;
        send_cmd(3'd4, 32'h0102_0304);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge sysClk);
            if (send_cnt != s0) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++; errors++; $display("FAIL midrst_send_bound: send pulses %0d required 1", send_cnt - s0);
        end
        repeat (3) @(negedge sysClk);
        @(posedge sysClk);
        #1 reset = 1'b1;
        @(negedge sysClk);
        checks++; if ({send, tx_wr, rx_rd} !== 3'b111) begin errors++; $display("FAIL midrst_strobes: got %b required 111", {send, tx_wr, rx_rd}); end
        checks++; if ((rsp_valid !== 1'b0) || (req_ready !== 1'b0)) begin
            errors++; $display("FAIL midrst_valid_ready: got v=%b rdy=%b required 0 0", rsp_valid, req_ready);
        end
        @(posedge sysClk);
        #1 reset = 1'b0;
        @(negedge sysClk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready_after: got %b required 1", req_ready); end
        for (int i = 0; i < 50 && io_complete !== 1'b1; i++) @(negedge sysClk);
        busy_len = 3;
        push_expect(3'd1, 32'h0000_007E);
        send_cmd(3'd1, 32'h0000_007E);
        get_rsp(ok, e);
        if (ok) begin
            checks++; if ((rsp_data !== e.data) || (rsp_err !== e.err)) begin
                errors++; $display("FAIL midrst_new_cmd: got %h/%b required %h/%b", rsp_data, rsp_err, e.data, e.err);
            end
        end
    endtask

`ifdef SPI_XFER_TIMEOUT_EN
    task automatic test_timeout();
        bit   ok;
        rsp_t e;
        rsp_ready = 1'b1;
        stuck = 1'b1;
        e.data = '0;
        e.err  = 1'b1;
        exp_q.push_back(e);
        send_cmd(3'd2, 32'h0000_ABCD);
        get_rsp(ok, e);
        if (ok) begin
            checks++; if (cyc - arm_mark != 16) begin errors++; $display("FAIL timeout_latency: got %0d cycles required 16", cyc - arm_mark); end
            checks++; if ((rsp_err !== e.err) || (rsp_data !== e.data)) begin
                errors++; $display("FAIL timeout_rsp: got %h/%b required %h/%b", rsp_data, rsp_err, e.data, e.err);
            end
        end
        stuck = 1'b0;
        repeat (3) @(negedge sysClk);
    endtask
`endif

    initial begin
        #300000;
        $display("FAIL global_bound: simulation time limit reached, required normal completion");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_len3();
        test_len4();
        test_bad_len();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
`ifdef SPI_XFER_TIMEOUT_EN
        test_timeout();
`endif
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d responses outstanding, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
